serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Bit-serial adder controller that sequences a single shared 1-bit full-adder cell across WIDTH cycles, adding two WIDTH-bit operands LSB-first. It sits beside the full-adder datapath cell. It owns operand capture, carry recirculation, bit counting, result assembly and the start/done handshake. It trades latency for area wherever a wide ripple adder is not justified.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- start  input  1  request; sampled on clk edge, accepted only in IDLE or DONE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle pulse; high while state is DONE.
- sum  output  WIDTH  result; valid while done is high, held until the next accept.
- cout  output  1  final carry-out; same validity as sum.
- ovf  output  1  signed overflow; present only with SERIAL_ADD_OVF_EN.

## Operation
- Internal state:
  - A/B shift registers (WIDTH each).
  - carry flop.
  - sum shift register (WIDTH).
  - bit counter, width $clog2(WIDTH+1).
  - 2-bit FSM.
- Exactly one full-adder cell is instantiated. Its inputs are A[0], B[0] and the carry flop.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - start=1 → capture a, b, cin into A, B and carry; clear counter; go to RUN.
- RUN, each cycle:
  - Shift the full-adder sum into the sum register MSB; the sum register shifts right.
  - carry ← full-adder carry.
  - A and B shift right.
  - counter+1.
  - When counter reaches WIDTH-1 on this edge, go to DONE.
- DONE:
  - done=1; sum and cout (cout = carry flop) are valid.
  - start=1 → accept exactly as in IDLE (back-to-back operation, no idle bubble).
  - Otherwise go to IDLE.
- start in RUN is ignored and is not queued. Operand inputs are don't-care except on the accepting edge.
- Arithmetic: sum = (a + b + cin) mod 2^WIDTH; cout = bit WIDTH of the same sum. Operands are unsigned for sum/cout.
- sum and cout retain their last result through IDLE and are not cleared by done falling. The sum register shows partial data during RUN; the bench must not check sum while busy.
- Reset (any time, including mid-RUN):
  - FSM → IDLE.
  - busy=0, done=0, sum=0, cout=0, ovf=0.
  - Counter, carry and operand registers cleared.
  - The in-flight operation is discarded with no done pulse.
- Illegal FSM encoding → IDLE on the next edge.

## Timing
- Accept on edge k.
- busy=1 after edges k through k+WIDTH-1 (WIDTH cycles).
- State DONE after edge k+WIDTH: done=1, result valid.
- Latency from the accepting edge to done is WIDTH+1 edges. Throughput is one result per WIDTH+1 cycles when start is held high.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- SERIAL_ADD_OVF_EN defined:
  - Port ovf exists.
  - During the last RUN cycle (counter = WIDTH-1), ovf ← carry-into-MSB XOR carry-out-of-MSB.
  - ovf is valid and held with the same rules as cout; reset value 0.
- Undefined:
  - ovf port and its logic are absent.
  - All other behaviour is identical.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, cin=0, single start pulse → busy for 8 cycles; done high on cycle 9 for exactly 1 cycle; sum=0x96, cout=0, ovf=1.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0. Then a=0x00, b=0x00, cin=1 → sum=0x01, cout=0.
- a=0x7F, b=0x01, cin=0 → sum=0x80, cout=0, ovf=1 (with macro). Rebuild without the macro → identical sum/cout and no ovf port.
- Start pulses with new operands on RUN cycles 2 and 5 → ignored; result matches the first operands; only one done pulse.
- start held high with operand sets (0x10,0x20,0) then (0xF0,0x20,1) → done pulses 9 cycles apart; results 0x30/cout 0, then 0x11/cout 1; no IDLE cycle between them.
- rst_n asserted low for 1 cycle at RUN cycle 4 → all outputs 0 immediately; no done pulse; a subsequent start completes normally.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one shared full-adder cell walks two WIDTH-bit operands LSB-first.
// Optional signed-overflow output is enabled by defining SERIAL_ADD_OVF_EN.

module FullAdderCell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_opA;
  logic [WIDTH-1:0] r_opB;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             w_faSum;
  logic             w_faCarry;
  logic             w_accept;
  logic             w_lastBit;

  FullAdderCell u_fa (
    .i_a(r_opA[0]),
    .i_b(r_opB[0]),
    .i_c(r_carry),
    .o_s(w_faSum),
    .o_c(w_faCarry)
  );

  assign w_accept  = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_lastBit = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // DONE with start high re-enters RUN directly so back-to-back adds have no bubble.
  always_comb begin
    w_nextState = IDLE;
    case (r_state)
      IDLE:    w_nextState = start ? RUN : IDLE;
      RUN:     w_nextState = w_lastBit ? DONE : RUN;
      DONE:    w_nextState = start ? RUN : IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opA   <= '0;
      r_opB   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_opA   <= a;
      r_opB   <= b;
      r_carry <= cin;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_sum   <= {w_faSum, r_sum[WIDTH-1:1]};
      r_carry <= w_faCarry;
      r_opA   <= r_opA >> 1;
      r_opB   <= r_opB >> 1;
      r_cnt   <= r_cnt + CW'(1);
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic r_ovf;

  // On the MSB step the carry flop holds the carry into the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if ((r_state == RUN) && w_lastBit) begin
      r_ovf <= r_carry ^ w_faCarry;
    end
  end

  assign ovf = r_ovf;
`endif

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign sum  = r_sum;
  assign cout = r_carry;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed cases plus randomized operations
// compared against a plain-arithmetic reference model.

module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad = 0;
  int cycle = 0;
  int lastDoneCycle = -100;
  bit prevHeld = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic applyStimulus(input logic s, input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    start = s;
    a     = ta;
    b     = tb;
    cin   = tc;
  endtask

  // Reference: unsigned sum with carry, signed overflow from operand/result signs.
  function automatic logic [W:0] refSum(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    return {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
  endfunction

  function automatic logic refOvf(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    logic [W:0] s;
    s = refSum(ta, tb, tc);
    return (ta[W-1] == tb[W-1]) && (s[W-1] != ta[W-1]);
  endfunction

  // Called from IDLE or DONE; leaves the DUT in DONE if holdStart, else in IDLE.
  task automatic doOp(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                      input bit disturb, input bit holdStart);
    logic [W:0] expSum;
    int doneSeen;
    expSum = refSum(ta, tb, tc);
    doneSeen = 0;
    applyStimulus(1'b1, ta, tb, tc);
    tick();
    applyStimulus(holdStart, W'($urandom), W'($urandom), 1'($urandom));
    checkOutput("busy_after_accept", busy, 1'b1);
    checkOutput("done_after_accept", done, 1'b0);
    for (int i = 1; i < W; i++) begin
      if (disturb && (i == 2 || i == 5))
        applyStimulus(1'b1, W'($urandom), W'($urandom), 1'($urandom));
      else
        start = holdStart;
      tick();
      if (busy !== 1'b1) checkOutput("busy_run", busy, 1'b1);
      if (done !== 1'b0) doneSeen++;
    end
    checkOutput("no_early_done", doneSeen, 0);
    start = holdStart;
    tick();
    checkOutput("done_pulse", done, 1'b1);
    checkOutput("busy_at_done", busy, 1'b0);
    checkOutput("sum", sum, expSum[W-1:0]);
    checkOutput("cout", cout, expSum[W]);
`ifdef SERIAL_ADD_OVF_EN
    checkOutput("ovf", ovf, refOvf(ta, tb, tc));
`endif
    if (prevHeld) checkOutput("b2b_spacing", cycle - lastDoneCycle, W + 1);
    lastDoneCycle = cycle;
    prevHeld = holdStart;
    if (!holdStart) begin
      applyStimulus(1'b0, W'($urandom), W'($urandom), 1'($urandom));
      tick();
      checkOutput("done_falls", done, 1'b0);
      checkOutput("idle_not_busy", busy, 1'b0);
      checkOutput("sum_held", sum, expSum[W-1:0]);
      checkOutput("cout_held", cout, expSum[W]);
    end
  endtask

  initial begin
    int doneCount;
    rst_n = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0);
    repeat (2) tick();
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_sum", sum, 0);
    checkOutput("rst_cout", cout, 1'b0);
`ifdef SERIAL_ADD_OVF_EN
    checkOutput("rst_ovf", ovf, 1'b0);
`endif
    rst_n = 1'b1;
    tick();

    doOp(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
    doOp(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    doOp(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    doOp(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
    doOp(8'h12, 8'h34, 1'b1, 1'b1, 1'b0);
    doOp(8'h10, 8'h20, 1'b0, 1'b0, 1'b1);
    doOp(8'hF0, 8'h20, 1'b1, 1'b0, 1'b0);

    // Reset mid-RUN: outputs clear asynchronously and the operation never completes.
    applyStimulus(1'b1, 8'hAB, 8'hCD, 1'b1);
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", busy, 1'b0);
    checkOutput("midrst_done", done, 1'b0);
    checkOutput("midrst_sum", sum, 0);
    checkOutput("midrst_cout", cout, 1'b0);
`ifdef SERIAL_ADD_OVF_EN
    checkOutput("midrst_ovf", ovf, 1'b0);
`endif
    tick();
    rst_n = 1'b1;
    doneCount = 0;
    for (int i = 0; i < W + 3; i++) begin
      tick();
      if (done) doneCount++;
    end
    checkOutput("midrst_no_done", doneCount, 0);
    prevHeld = 0;
    doOp(8'h5A, 8'hA5, 1'b1, 1'b0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      doOp(W'($urandom), W'($urandom), 1'($urandom),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
    end
    doOp(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
